// File: rtl/mesi_rr_bus_arbiter.sv
// mesi_rr_bus_arbiter: round-robin bus arbiter for MESI cache cores with a per-tenure hold limit
module mesi_rr_bus_arbiter #(
  parameter int N_CORES  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(N_CORES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] done,
  output logic [N_CORES-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  typedef enum logic {IDLE, OWNED} state_t;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, grant_id_q, grant_id_d, win_id, idx;
  logic [N_CORES-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d, timeout_q, timeout_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               at_limit, rel;
  // pick the first requester at or above ptr (scan runs far-to-near so the nearest wins)
  always_comb begin
    win_id = '0;
    idx = '0;
    for (int k = N_CORES-1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_CORES);
      if (req[idx]) win_id = idx;
    end
  end
  assign at_limit = hold_q == HW'(MAX_HOLD-1);
  assign rel      = done[grant_id_q] | ~req[grant_id_q] | at_limit;
  // next-state: grant from IDLE, release from OWNED with a forced idle turnaround
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    hold_d        = hold_q;
    timeout_d     = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d       = OWNED;
        grant_d       = N_CORES'(1) << win_id;
        grant_id_d    = win_id;
        grant_valid_d = 1'b1;
        hold_d        = '0;
      end
    end else if (rel) begin
      state_d       = IDLE;
      grant_d       = '0;
      grant_id_d    = '0;
      grant_valid_d = 1'b0;
      hold_d        = '0;
      ptr_d         = (int'(grant_id_q) == N_CORES-1) ? '0 : grant_id_q + 1'b1;
      timeout_d     = at_limit & ~done[grant_id_q] & req[grant_id_q];
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      hold_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      hold_q        <= hold_d;
      timeout_q     <= timeout_d;
    end
  end
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;
endmodule
